// File: rtl/bus_timer_pkg.sv
// Shared bus-slave handshake and timer register definitions for bus_timer.
// Imported by the reusable slave controller and by the timer core.
package bus_timer_pkg;

    localparam int WORD_DATA_W       = 32;
    localparam int BUS_SLAVE_STATE_BUS = 2;

    typedef enum logic [BUS_SLAVE_STATE_BUS-1:0] {
        BUS_SLAVE_STATE_IDLE = 2'd0,
        BUS_SLAVE_STATE_WAIT = 2'd1,
        BUS_SLAVE_STATE_RESP = 2'd2
    } bus_slave_state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
    localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
    localparam logic [1:0] TIMER_ADDR_EXPIRE  = 2'd2;
    localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

    localparam int TIMER_START_LOC    = 0;
    localparam int TIMER_PERIODIC_LOC = 1;
    localparam int TIMER_IRQ_LOC      = 0;

endpackage

// File: rtl/bus_slave_ctrl.sv
// Bus slave handshake: latches a chip-selected access, optional wait states (BUS_TIMER_WAIT_EN),
// one-cycle registered BusRdy_/read data; strobes the latched write on the cycle that ends RESP.
module bus_slave_ctrl
    import bus_timer_pkg::*;
`ifdef BUS_TIMER_WAIT_EN
#(
    parameter int WAIT_STATES = 0
)
`endif
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_n_i,
    input  logic                   as_n_i,
    input  logic [1:0]             addr_i,
    input  logic                   rw_i,
    input  logic [WORD_DATA_W-1:0] wr_data_i,
    input  logic [WORD_DATA_W-1:0] rd_data_i,
    output logic [1:0]             rd_idx_o,
    output logic                   wr_stb_o,
    output logic [1:0]             idx_o,
    output logic [WORD_DATA_W-1:0] wr_data_o,
    output logic                   rdy_n_o,
    output logic [WORD_DATA_W-1:0] rd_data_o
);

    bus_slave_state_e       state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic                   rw_q, rw_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
    logic                   rdy_n_q, rdy_n_d;
    logic [WORD_DATA_W-1:0] rdata_q, rdata_d;
    logic                   req;

`ifdef BUS_TIMER_WAIT_EN
    localparam int WAIT_CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
`endif

    assign req = !cs_n_i && !as_n_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
`ifdef BUS_TIMER_WAIT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            BUS_SLAVE_STATE_IDLE: begin
                if (req) begin
                    idx_d   = addr_i;
                    rw_d    = rw_i;
                    wdata_d = wr_data_i;
                    state_d = BUS_SLAVE_STATE_RESP;
`ifdef BUS_TIMER_WAIT_EN
                    if (WAIT_STATES > 0) begin
                        state_d = BUS_SLAVE_STATE_WAIT;
                        wait_d  = WAIT_CNT_W'(WAIT_STATES);
                    end
`endif
                end
            end
`ifdef BUS_TIMER_WAIT_EN
            BUS_SLAVE_STATE_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WAIT_CNT_W'(1)) state_d = BUS_SLAVE_STATE_RESP;
            end
`endif
            BUS_SLAVE_STATE_RESP: state_d = BUS_SLAVE_STATE_IDLE;
            default:              state_d = BUS_SLAVE_STATE_IDLE;
        endcase
    end

    // Read data is captured on the edge entering RESP, so with no wait
    // states the index comes straight from the bus.
    assign rd_idx_o = (state_q == BUS_SLAVE_STATE_IDLE) ? addr_i : idx_q;
    assign rdy_n_d  = (state_d != BUS_SLAVE_STATE_RESP);
    assign rdata_d  = (state_d == BUS_SLAVE_STATE_RESP) ? rd_data_i : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUS_SLAVE_STATE_IDLE;
            idx_q   <= '0;
            rw_q    <= READ;
            wdata_q <= '0;
            rdy_n_q <= 1'b1;
            rdata_q <= '0;
`ifdef BUS_TIMER_WAIT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdy_n_q <= rdy_n_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMER_WAIT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    assign wr_stb_o  = (state_q == BUS_SLAVE_STATE_RESP) && (rw_q == WRITE);
    assign idx_o     = idx_q;
    assign wr_data_o = wdata_q;
    assign rdy_n_o   = rdy_n_q;
    assign rd_data_o = rdata_q;

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit interval timer with level Irq; BUS_TIMER_WAIT_EN adds WAIT_STATES wait cycles.
// BusRdy_ low for one cycle at 1 (+WAIT_STATES) cycles after BusAs_; accesses during a transaction are ignored.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   BusCs_,
    input  logic                   BusAs_,
    input  logic [1:0]             BusAddr,
    input  logic                   BusRW,
    input  logic [WORD_DATA_W-1:0] BusWrData,
    output logic [WORD_DATA_W-1:0] BusRdData,
    output logic                   BusRdy_,
    output logic                   Irq
);

    logic [1:0]             rd_idx, wr_idx;
    logic                   wr_stb;
    logic [WORD_DATA_W-1:0] wr_dat, rd_dat;

    logic                   start_q, start_d, periodic_q, periodic_d, irq_q, irq_d;
    logic [WORD_DATA_W-1:0] expire_q, expire_d, counter_q, counter_d;
    logic                   expired;

    if (WAIT_STATES < 0) begin : g_bad_wait_states
        $error("bus_timer: WAIT_STATES must be non-negative");
    end

`ifdef BUS_TIMER_WAIT_EN
    bus_slave_ctrl #(.WAIT_STATES(WAIT_STATES)) u_slave (
`else
    bus_slave_ctrl u_slave (
`endif
        .clk       (clk),
        .reset     (reset),
        .cs_n_i    (BusCs_),
        .as_n_i    (BusAs_),
        .addr_i    (BusAddr),
        .rw_i      (BusRW),
        .wr_data_i (BusWrData),
        .rd_data_i (rd_dat),
        .rd_idx_o  (rd_idx),
        .wr_stb_o  (wr_stb),
        .idx_o     (wr_idx),
        .wr_data_o (wr_dat),
        .rdy_n_o   (BusRdy_),
        .rd_data_o (BusRdData)
    );

    assign expired = start_q && (counter_q == expire_q);

    // Bus writes are applied last so they override the counter's own update;
    // an expiry still beats an INTR clear on the same edge.
    always_comb begin
        start_d    = start_q;
        periodic_d = periodic_q;
        irq_d      = irq_q;
        expire_d   = expire_q;
        counter_d  = counter_q;
        if (start_q) counter_d = expired ? '0 : counter_q + 1'b1;
        if (expired) begin
            irq_d = 1'b1;
            if (!periodic_q) start_d = 1'b0;
        end
        if (wr_stb) begin
            case (wr_idx)
                TIMER_ADDR_CTRL: begin
                    start_d    = wr_dat[TIMER_START_LOC];
                    periodic_d = wr_dat[TIMER_PERIODIC_LOC];
                end
                TIMER_ADDR_INTR:    if (!wr_dat[TIMER_IRQ_LOC] && !expired) irq_d = 1'b0;
                TIMER_ADDR_EXPIRE:  expire_d  = wr_dat;
                TIMER_ADDR_COUNTER: counter_d = wr_dat;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_dat = '0;
        case (rd_idx)
            TIMER_ADDR_CTRL: begin
                rd_dat[TIMER_START_LOC]    = start_q;
                rd_dat[TIMER_PERIODIC_LOC] = periodic_q;
            end
            TIMER_ADDR_INTR:    rd_dat[TIMER_IRQ_LOC] = irq_q;
            TIMER_ADDR_EXPIRE:  rd_dat = expire_q;
            TIMER_ADDR_COUNTER: rd_dat = counter_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            expire_q   <= '0;
            counter_q  <= '0;
        end else begin
            start_q    <= start_d;
            periodic_q <= periodic_d;
            irq_q      <= irq_d;
            expire_q   <= expire_d;
            counter_q  <= counter_d;
        end
    end

    assign Irq = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized and directed bench for bus_timer against a transaction-level timer model.
module tb_bus_timer;
    import bus_timer_pkg::*;

    localparam int W_PARAM = 3;
`ifdef BUS_TIMER_WAIT_EN
    localparam int W = W_PARAM;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        BusCs_, BusAs_, BusRW;
    logic [1:0]  BusAddr;
    logic [31:0] BusWrData, BusRdData;
    logic        BusRdy_, Irq;

    bus_timer #(.WAIT_STATES(W_PARAM)) dut (
        .clk       (clk),
        .reset     (reset),
        .BusCs_    (BusCs_),
        .BusAs_    (BusAs_),
        .BusAddr   (BusAddr),
        .BusRW     (BusRW),
        .BusWrData (BusWrData),
        .BusRdData (BusRdData),
        .BusRdy_   (BusRdy_),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural registers plus one outstanding access
    logic        m_start, m_per, m_irq;
    logic [31:0] m_exp, m_cnt;
    logic        pend;
    int          pend_resp;
    logic [1:0]  pend_addr;
    logic        pend_rw;
    logic [31:0] pend_wd, pend_snap;

    int          cyc = 0;
    bit          chk_en = 0;
    int          rdy_cnt, rdy_at;
    logic [31:0] rd_val;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            TIMER_ADDR_CTRL:   return {30'd0, m_per, m_start};
            TIMER_ADDR_INTR:   return {31'd0, m_irq};
            TIMER_ADDR_EXPIRE: return m_exp;
            default:           return m_cnt;
        endcase
    endfunction

    task automatic model_clear();
        m_start = 0; m_per = 0; m_irq = 0; m_exp = 0; m_cnt = 0;
        pend = 0; pend_resp = -1; pend_snap = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, advance model, move to next negedge.
    task automatic cycle(input logic rst, input logic cs_n, input logic as_n,
                         input logic [1:0] a, input logic rw, input logic [31:0] wd);
        logic        resp_now, hit, n_start, n_per, n_irq;
        logic [31:0] n_cnt, n_exp;
        resp_now = pend && (cyc == pend_resp);
        if (chk_en) begin
            chk("BusRdy_", {31'd0, BusRdy_}, {31'd0, !resp_now});
            chk("BusRdData", BusRdData, resp_now ? pend_snap : 32'd0);
            chk("Irq", {31'd0, Irq}, {31'd0, m_irq});
        end
        if (BusRdy_ === 1'b0) begin
            rdy_cnt++;
            rdy_at = cyc;
            rd_val = BusRdData;
        end
        reset = rst; BusCs_ = cs_n; BusAs_ = as_n; BusAddr = a; BusRW = rw; BusWrData = wd;

        if (!pend && !cs_n && !as_n) begin
            pend = 1; pend_resp = cyc + 1 + W;
            pend_addr = a; pend_rw = rw; pend_wd = wd;
        end
        if (pend && cyc == pend_resp - 1) pend_snap = m_reg(pend_addr);

        hit     = m_start && (m_cnt == m_exp);
        n_cnt   = !m_start ? m_cnt : (hit ? 32'd0 : m_cnt + 32'd1);
        n_start = (hit && !m_per) ? 1'b0 : m_start;
        n_per   = m_per;
        n_irq   = m_irq | hit;
        n_exp   = m_exp;
        if (resp_now && pend_rw == WRITE) begin
            case (pend_addr)
                TIMER_ADDR_CTRL:   begin n_start = pend_wd[0]; n_per = pend_wd[1]; end
                TIMER_ADDR_INTR:   if (!pend_wd[0] && !hit) n_irq = 1'b0;
                TIMER_ADDR_EXPIRE: n_exp = pend_wd;
                default:           n_cnt = pend_wd;
            endcase
        end
        if (resp_now) pend = 0;
        m_start = n_start; m_per = n_per; m_irq = n_irq; m_exp = n_exp; m_cnt = n_cnt;
        if (rst) model_clear();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 2'd0, READ, 32'd0);
    endtask

    // Full access: BusAs_ for one cycle, then idle up to the earliest next access slot.
    task automatic access(input logic [1:0] a, input logic rw, input logic [31:0] wd,
                          input bit extra_as, output logic [31:0] rd);
        int n0;
        n0 = cyc;
        rdy_cnt = 0;
        cycle(1'b0, 1'b0, 1'b0, a, rw, wd);
        if (extra_as) cycle(1'b0, 1'b0, 1'b0, TIMER_ADDR_EXPIRE, WRITE, 32'h1234_5678);
        else          cycle(1'b0, 1'b1, 1'b1, 2'd0, READ, 32'd0);
        idle(W);
        chk("rdy_pulses", 32'(rdy_cnt), 32'd1);
        chk("rdy_latency", 32'(rdy_at - n0), 32'(1 + W));
        rd = rd_val;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        access(a, WRITE, d, 1'b0, unused_rd);
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        access(a, READ, 32'd0, 1'b0, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1; BusCs_ = 1; BusAs_ = 1; BusAddr = 0; BusRW = READ; BusWrData = 0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0, READ, 32'd0);
        chk_en = 1;

        chk("rst_rdy", {31'd0, BusRdy_}, 32'd1);
        chk("rst_rdata", BusRdData, 32'd0);
        chk("rst_irq", {31'd0, Irq}, 32'd0);
        rd_expect("rst_ctrl", TIMER_ADDR_CTRL, 32'd0);
        rd_expect("rst_intr", TIMER_ADDR_INTR, 32'd0);
        rd_expect("rst_expire", TIMER_ADDR_EXPIRE, 32'd0);
        rd_expect("rst_counter", TIMER_ADDR_COUNTER, 32'd0);

        // Periodic mode, EXPIRE=5
        wr(TIMER_ADDR_EXPIRE, 32'd5);
        wr(TIMER_ADDR_CTRL, 32'd3);
        idle(5);
        chk("periodic_irq_early", {31'd0, Irq}, 32'd0);
        idle(1);
        chk("periodic_irq_rise", {31'd0, Irq}, 32'd1);
        for (int i = 0; i < 4; i++) access(TIMER_ADDR_COUNTER, READ, 32'd0, 1'b0, v);
        rd_expect("periodic_ctrl", TIMER_ADDR_CTRL, 32'd3);

        // One-shot mode, EXPIRE=2
        wr(TIMER_ADDR_CTRL, 32'd0);
        wr(TIMER_ADDR_INTR, 32'd0);
        wr(TIMER_ADDR_COUNTER, 32'd0);
        wr(TIMER_ADDR_EXPIRE, 32'd2);
        wr(TIMER_ADDR_CTRL, 32'd1);
        idle(8);
        rd_expect("oneshot_ctrl", TIMER_ADDR_CTRL, 32'd0);
        rd_expect("oneshot_counter", TIMER_ADDR_COUNTER, 32'd0);
        chk("oneshot_irq", {31'd0, Irq}, 32'd1);
        wr(TIMER_ADDR_INTR, 32'd0);
        chk("irq_cleared", {31'd0, Irq}, 32'd0);

        // Read latency and data
        wr(TIMER_ADDR_EXPIRE, 32'hDEAD_BEEF);
        rd_expect("expire_rd", TIMER_ADDR_EXPIRE, 32'hDEAD_BEEF);

        // Strobe without chip select, and a second strobe while busy
        cycle(1'b0, 1'b1, 1'b0, TIMER_ADDR_EXPIRE, WRITE, 32'd0);
        idle(W + 3);
        rd_expect("cs_high_ignored", TIMER_ADDR_EXPIRE, 32'hDEAD_BEEF);
        access(TIMER_ADDR_COUNTER, READ, 32'd0, 1'b1, v);
        idle(W + 3);
        rd_expect("busy_as_ignored", TIMER_ADDR_EXPIRE, 32'hDEAD_BEEF);

        // EXPIRE=0 running: INTR clear collides with expiry, CTRL write wins over expiry
        wr(TIMER_ADDR_EXPIRE, 32'd0);
        wr(TIMER_ADDR_COUNTER, 32'd0);
        wr(TIMER_ADDR_CTRL, 32'd3);
        idle(2);
        chk("every_cycle_irq", {31'd0, Irq}, 32'd1);
        wr(TIMER_ADDR_INTR, 32'd0);
        chk("clear_vs_expiry", {31'd0, Irq}, 32'd1);
        wr(TIMER_ADDR_CTRL, 32'd0);
        rd_expect("ctrl_write_wins", TIMER_ADDR_CTRL, 32'd0);
        rd_expect("counter_held", TIMER_ADDR_COUNTER, 32'd0);

        // Reset while the access is still outstanding
        wr(TIMER_ADDR_EXPIRE, 32'd9);
        wr(TIMER_ADDR_COUNTER, 32'd4);
        rdy_cnt = 0;
        for (int i = 0; i <= W; i++)
            cycle(i == W, i != 0, i != 0, TIMER_ADDR_COUNTER, READ, 32'd0);
        idle(W + 3);
        chk("rst_mid_no_rdy", 32'(rdy_cnt), 32'd0);
        chk("rst_mid_irq", {31'd0, Irq}, 32'd0);
        rd_expect("rst_mid_ctrl", TIMER_ADDR_CTRL, 32'd0);
        rd_expect("rst_mid_intr", TIMER_ADDR_INTR, 32'd0);
        rd_expect("rst_mid_expire", TIMER_ADDR_EXPIRE, 32'd0);
        rd_expect("rst_mid_counter", TIMER_ADDR_COUNTER, 32'd0);

        // Random traffic: overlapping strobes, stray chip selects, occasional reset
        for (int k = 0; k < 600; k++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), d);
        end
        idle(W + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
